// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron feeder.
//   feeder_state_t : FSM encoding (weight load / sample delivery)
//   NUM_WEIGHTS    : number of serial weight bits (w2 arrives first, w0 last)
//   WT_LAST_IDX    : bit index of the final serial weight bit (w0)
//   DEFAULT_DEPTH  : default sample FIFO depth
package neuron_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } feeder_state_t;

    localparam int         NUM_WEIGHTS   = 3;
    localparam logic [1:0] WT_LAST_IDX   = 2'd2;
    localparam int         DEFAULT_DEPTH = 4;

endpackage

// File: rtl/neuron_feeder_sample_fifo.sv
// sample_fifo: 2-bit wide, DEPTH-entry synchronous FIFO for {x1,x0} pairs.
// Ports:
//   clk, rst      clock, synchronous active-high reset (flushes the FIFO)
//   push, wdata   write request and data; ignored when full
//   pop           read request; ignored when empty
//   rdata         head entry, forced to 0 when empty
//   full, empty   occupancy flags derived from the internal entry count
module sample_fifo
    import neuron_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [1:0] wdata,
    input  logic       pop,
    output logic [1:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? 2'b00 : mem[rd_ptr];

    // Storage needs no reset: the empty mux hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/neuron_feeder.sv
// neuron_feeder: loads three serial weight bits, buffers {x1,x0} sample pairs
// and hands them to the neuron over a valid/ready interface.
// Optional feature macro: FEEDER_CNT_EN adds the saturating sample_cnt output.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cfg_start                 discard weights and (re)start loading
//   cfg_bit, cfg_valid        serial weight bit and its qualifier (w2 first)
//   in_valid, in_x, in_ready  upstream sample handshake, in_x = {x1,x0}
//   out_valid, out_ready      downstream handshake
//   x0, x1                    FIFO head pair
//   w0, w1, w2, wt_loaded     registered weights and load-complete flag
//   sample_cnt                pairs delivered, saturating (FEEDER_CNT_EN only)
//
// state   | meaning
// ST_LOAD | shifting in weight bits; sample handshakes closed
// ST_RUN  | weights stable; FIFO accepts and delivers pairs
module neuron_feeder
    import neuron_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
`ifdef FEEDER_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_bit,
    input  logic             cfg_valid,
    input  logic             in_valid,
    input  logic [1:0]       in_x,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             x0,
    output logic             x1,
    output logic             w0,
    output logic             w1,
    output logic             w2,
    output logic             wt_loaded
`ifdef FEEDER_CNT_EN
    ,
    output logic [CNT_W-1:0] sample_cnt
`endif
);

    feeder_state_t          state;
    logic [1:0]             bit_idx;
    logic [NUM_WEIGHTS-1:0] weights;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [1:0]             head;
    logic                   push;
    logic                   pop;

    // FIFO contents survive a trip back to ST_LOAD but stay hidden until ST_RUN.
    assign in_ready  = (state == ST_RUN) && !fifo_full;
    assign out_valid = (state == ST_RUN) && !fifo_empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign x0        = head[0];
    assign x1        = head[1];
    assign w2        = weights[2];
    assign w1        = weights[1];
    assign w0        = weights[0];

    sample_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_x),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Weights shift left, so the first bit received ends up in w2.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            bit_idx   <= 2'd0;
            weights   <= '0;
            wt_loaded <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (cfg_start) begin
                        bit_idx <= 2'd0;
                        weights <= '0;
                    end else if (cfg_valid) begin
                        weights <= {weights[NUM_WEIGHTS-2:0], cfg_bit};
                        if (bit_idx == WT_LAST_IDX) begin
                            state     <= ST_RUN;
                            bit_idx   <= 2'd0;
                            wt_loaded <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 2'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cfg_start) begin
                        state     <= ST_LOAD;
                        bit_idx   <= 2'd0;
                        weights   <= '0;
                        wt_loaded <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

`ifdef FEEDER_CNT_EN
    // Only rst clears the count; reloading weights keeps the history.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (pop && (sample_cnt != '1)) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed, table-driven bench for neuron_feeder. Each table row holds the
// inputs driven during one cycle and the outputs expected in that same cycle
// (sampled on the falling edge, before the rising edge acts on the inputs).
module tb_neuron_feeder;

    logic       clk = 1'b0;
    logic       rst, cfg_start, cfg_bit, cfg_valid;
    logic       in_valid, out_ready;
    logic [1:0] in_x;
    logic       in_ready, out_valid, x0, x1, w0, w1, w2, wt_loaded;
`ifdef FEEDER_CNT_EN
    logic [7:0] sample_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    neuron_feeder #(
        .DEPTH(4)
`ifdef FEEDER_CNT_EN
        ,
        .CNT_W(8)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x0        (x0),
        .x1        (x1),
        .w0        (w0),
        .w1        (w1),
        .w2        (w2),
        .wt_loaded (wt_loaded)
`ifdef FEEDER_CNT_EN
        ,
        .sample_cnt(sample_cnt)
`endif
    );

    typedef struct {
        logic       r, cs, cb, cv, iv;
        logic [1:0] ix;
        logic       ordy;
        logic       e_ir, e_ov;
        logic [1:0] e_x;
        logic [2:0] e_w;
        logic       e_wl;
        logic [1:0] skip;   // [0] skip weight check, [1] skip x check
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, cs, cb, cv, iv, input logic [1:0] ix, input logic ordy,
                       input logic e_ir, e_ov, input logic [1:0] e_x, input logic [2:0] e_w,
                       input logic e_wl, input logic [1:0] skip);
        vec_t v;
        v.r = r; v.cs = cs; v.cb = cb; v.cv = cv; v.iv = iv; v.ix = ix; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_x = e_x; v.e_w = e_w; v.e_wl = e_wl; v.skip = skip;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, cs, cb, cv, iv, input logic [1:0] ix, input logic ordy);
        rst = r; cfg_start = cs; cfg_bit = cb; cfg_valid = cv;
        in_valid = iv; in_x = ix; out_ready = ordy;
    endtask

    task automatic cyc(input logic r, cs, cb, cv, iv, input logic [1:0] ix, input logic ordy);
        drive(r, cs, cb, cv, iv, ix, ordy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   r cs cb cv iv ix     ordy | ir ov x      w       wl skip
        // reset state
        add(1, 0, 0, 0, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b00);
        // load weights 1,0,1 -> w2=1 w1=0 w0=1
        add(0, 0, 1, 1, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b00);
        add(0, 0, 0, 1, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b01);
        add(0, 0, 1, 1, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b01);
        add(0, 0, 0, 0, 0, 2'b00, 0,   1, 0, 2'b00, 3'b101, 1, 2'b00);
        // push 01,10,11 held, then drain in order
        add(0, 0, 0, 0, 1, 2'b01, 0,   1, 0, 2'b00, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 1, 2'b10, 0,   1, 1, 2'b01, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 1, 2'b11, 0,   1, 1, 2'b01, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 0,   1, 1, 2'b01, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 1,   1, 1, 2'b01, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 1,   1, 1, 2'b10, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 1,   1, 1, 2'b11, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 0,   1, 0, 2'b00, 3'b101, 1, 2'b00);
        // fill to 4, 5th offer refused (also with a pop the same cycle)
        add(0, 0, 0, 0, 1, 2'b00, 0,   1, 0, 2'b00, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 1, 2'b01, 0,   1, 1, 2'b00, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 1, 2'b10, 0,   1, 1, 2'b00, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 1, 2'b11, 0,   1, 1, 2'b00, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 1, 2'b01, 0,   0, 1, 2'b00, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 1, 2'b01, 1,   0, 1, 2'b00, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 1,   1, 1, 2'b01, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 1,   1, 1, 2'b10, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 1,   1, 1, 2'b11, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 0,   1, 0, 2'b00, 3'b101, 1, 2'b00);
        // 2 queued, push+pop together, then count proven still 2
        add(0, 0, 0, 0, 1, 2'b10, 0,   1, 0, 2'b00, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 1, 2'b11, 0,   1, 1, 2'b10, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 1, 2'b01, 1,   1, 1, 2'b10, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 0,   1, 1, 2'b11, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 1, 2'b10, 0,   1, 1, 2'b11, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 1, 2'b11, 0,   1, 1, 2'b11, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 0,   0, 1, 2'b11, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 1,   0, 1, 2'b11, 3'b101, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 0,   1, 1, 2'b01, 3'b101, 1, 2'b00);
        // cfg_start with 01,10,11 queued; cfg_start beats cfg_valid; reload 0,1,1
        add(0, 1, 0, 0, 0, 2'b00, 0,   1, 1, 2'b01, 3'b101, 1, 2'b00);
        add(0, 1, 1, 1, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b10);
        add(0, 0, 0, 1, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b10);
        add(0, 0, 1, 1, 1, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b11);
        add(0, 0, 1, 1, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b11);
        add(0, 0, 0, 0, 0, 2'b00, 1,   1, 1, 2'b01, 3'b011, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 1,   1, 1, 2'b10, 3'b011, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 1,   1, 1, 2'b11, 3'b011, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 0,   1, 0, 2'b00, 3'b011, 1, 2'b00);
        // rst mid-stream
        add(0, 0, 0, 0, 1, 2'b01, 0,   1, 0, 2'b00, 3'b011, 1, 2'b00);
        add(0, 0, 0, 0, 1, 2'b10, 0,   1, 1, 2'b01, 3'b011, 1, 2'b00);
        add(1, 0, 0, 0, 1, 2'b11, 0,   1, 1, 2'b01, 3'b011, 1, 2'b00);
        add(0, 0, 0, 0, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b00);
        // rst mid-load after 2 bits, then a fresh 0,0,1 load needs all 3 bits
        add(0, 0, 1, 1, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b00);
        add(0, 0, 1, 1, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b01);
        add(1, 0, 0, 0, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b01);
        add(0, 0, 0, 0, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b00);
        add(0, 0, 0, 1, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b00);
        add(0, 0, 0, 1, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b01);
        add(0, 0, 1, 1, 0, 2'b00, 0,   0, 0, 2'b00, 3'b000, 0, 2'b01);
        add(0, 0, 0, 0, 0, 2'b00, 0,   1, 0, 2'b00, 3'b001, 1, 2'b00);

        drive(1, 0, 0, 0, 0, 2'b00, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].cs, vecs[i].cb, vecs[i].cv, vecs[i].iv, vecs[i].ix, vecs[i].ordy);
            @(negedge clk);
            check("in_ready", i, {7'd0, in_ready}, {7'd0, vecs[i].e_ir});
            check("out_valid", i, {7'd0, out_valid}, {7'd0, vecs[i].e_ov});
            check("wt_loaded", i, {7'd0, wt_loaded}, {7'd0, vecs[i].e_wl});
            if (!vecs[i].skip[1])
                check("x1x0", i, {6'd0, x1, x0}, {6'd0, vecs[i].e_x});
            if (!vecs[i].skip[0])
                check("w2w1w0", i, {5'd0, w2, w1, w0}, {5'd0, vecs[i].e_w});
            @(posedge clk);
            #1;
        end

`ifdef FEEDER_CNT_EN
        cyc(1, 0, 0, 0, 0, 2'b00, 0);
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        @(negedge clk);
        check("cnt_reset", 0, sample_cnt, 8'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 2'b00, 0);
        // first stream cycle only pushes; the next 5 each pop once
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 2'b01, 1);
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        @(negedge clk);
        check("cnt_5", 1, sample_cnt, 8'd5);
        @(posedge clk);
        #1;
        cyc(0, 1, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 2'b00, 0);
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        @(negedge clk);
        check("cnt_keep_cfg", 2, sample_cnt, 8'd5);
        @(posedge clk);
        #1;
        // one entry retained, so every streaming cycle pops: 5 + 300 saturates
        for (int i = 0; i < 300; i++) cyc(0, 0, 0, 0, 1, 2'b10, 1);
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        @(negedge clk);
        check("cnt_sat", 3, sample_cnt, 8'd255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
